// File: rtl/emisor_instrucciones_if.sv
// Host-side bundle of emisor_instrucciones: FIFO push, issue enable, issued word and status.
// master = host/bench side, slave = the issue unit.
interface emisor_instrucciones_if #(
   parameter int unsigned DEPTH = 8
);
   logic                      wr_en;
   logic [17:0]               wr_instr;
   logic                      run;
   logic [17:0]               instruccion;
   logic                      issued;
   logic                      stall;
   logic                      full;
   logic                      empty;
   logic [$clog2(DEPTH):0]    count;
   logic                      ovf;

   modport master (
      output wr_en, wr_instr, run,
      input  instruccion, issued, stall, full, empty, count, ovf
   );

   modport slave (
      input  wr_en, wr_instr, run,
      output instruccion, issued, stall, full, empty, count, ovf
   );
endinterface

// File: rtl/emisor_instrucciones.sv
// Instruction issue unit: FIFO feeding a registered 18-bit instruction port with RAW bubbles.
// Define EMISOR_SCOREBOARD_EN to enable the hazard interlock; otherwise issue is unconditional.
module emisor_instrucciones #(
   parameter int unsigned DEPTH     = 8,
   parameter logic [7:0]  WE_MASK   = 8'b0001_1110,
   parameter logic [17:0] NOP_INSTR = 18'h00000
) (
   input logic                   clk_emisor,
   input logic                   rst_emisor,
   emisor_instrucciones_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
`ifdef EMISOR_SCOREBOARD_EN
   localparam bit HAZ_EN = 1'b1;
`else
   localparam bit HAZ_EN = 1'b0;
`endif

   logic [17:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [17:0]   instr_q, instr_d, prev_q, prev_d;
   logic          issued_q, issued_d, stall_q, stall_d, ovf_q, ovf_d;
   logic [17:0]   head;
   logic          full, empty, push, pop, haz;

   // A producer conflicts when it writes the bank and its WA matches either source of the consumer.
   function automatic logic raw(input logic [17:0] prod, input logic [17:0] cons);
      return WE_MASK[prod[17:15]] &&
             ((prod[14:10] == cons[9:5]) || (prod[14:10] == cons[4:0]));
   endfunction

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign haz   = HAZ_EN && (raw(instr_q, head) || raw(prev_q, head));
   assign push  = bus.wr_en && !full;
   assign pop   = bus.run && !empty && !haz;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      prev_d   = instr_q;
      instr_d  = NOP_INSTR;
      issued_d = 1'b0;
      stall_d  = 1'b0;
      ovf_d    = ovf_q | (bus.wr_en && full);
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (!bus.run || empty) begin
         instr_d = NOP_INSTR;
      end else if (haz) begin
         stall_d = 1'b1;
      end else begin
         instr_d  = head;
         issued_d = 1'b1;
      end
   end

   always_ff @(posedge clk_emisor) begin
      if (!rst_emisor && push) mem_q[wr_ptr_q] <= bus.wr_instr;
   end

   always_ff @(posedge clk_emisor) begin
      if (rst_emisor) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         instr_q  <= NOP_INSTR;
         prev_q   <= NOP_INSTR;
         issued_q <= 1'b0;
         stall_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         instr_q  <= instr_d;
         prev_q   <= prev_d;
         issued_q <= issued_d;
         stall_q  <= stall_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.instruccion = instr_q;
   assign bus.issued      = issued_q;
   assign bus.stall       = stall_q;
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.count       = count_q;
   assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_emisor_instrucciones.sv
// Scoreboard bench for emisor_instrucciones; expected bubbles depend on EMISOR_SCOREBOARD_EN.
module tb_emisor_instrucciones;
   typedef struct packed {
      logic [17:0] instr;
      logic        stall;
      logic        consec;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   emisor_instrucciones_if #(.DEPTH(8)) bus();

   emisor_instrucciones #(
      .DEPTH(8),
      .WE_MASK(8'b0001_1110),
      .NOP_INSTR(18'h00000)
   ) dut (
      .clk_emisor(clk),
      .rst_emisor(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] mk(input logic [2:0] op, input logic [4:0] wa,
                                      input logic [4:0] ra1, input logic [4:0] ra2);
      return {op, wa, ra1, ra2};
   endfunction

   task automatic exp_issue(input logic [17:0] w, input logic consec);
      exp_t e;
      e.instr  = w;
      e.stall  = 1'b0;
      e.consec = consec;
      sb.push_back(e);
   endtask

   task automatic exp_bubble();
      exp_t e;
      e.instr  = 18'h00000;
      e.stall  = 1'b1;
      e.consec = 1'b1;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [17:0] w);
      bus.wr_en    = 1'b1;
      bus.wr_instr = w;
      step();
      bus.wr_en    = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         step();
         n++;
      end
      chk(name, 32'(sb.size()), 32'd0);
      repeat (4) step();
   endtask

   // Monitor: every output event (issue or bubble) consumes one scoreboard entry.
   initial begin
      int   mcyc = 0;
      int   last_ev = 0;
      exp_t e;
      forever begin
         step();
         mcyc++;
         if (bus.issued === 1'b1 || bus.stall === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%0h required=none", bus.instruccion);
            end else begin
               e = sb.pop_front();
               chk("sb_instr",  32'(bus.instruccion), 32'(e.instr));
               chk("sb_stall",  32'(bus.stall),       32'(e.stall));
               chk("sb_issued", 32'(bus.issued),      32'(!e.stall));
               if (e.consec) chk("sb_consecutive", 32'(mcyc - last_ev), 32'd1);
            end
            last_ev = mcyc;
         end
      end
   end

   logic [17:0] wa, wb, wc, wd, we, wa0;

   initial begin
      bus.wr_en    = 1'b0;
      bus.wr_instr = '0;
      bus.run      = 1'b0;
      wa  = mk(3'd1, 5'd5,  5'd1, 5'd2);
      wb  = mk(3'd1, 5'd6,  5'd3, 5'd4);
      wc  = mk(3'd1, 5'd7,  5'd8, 5'd9);
      wd  = mk(3'd1, 5'd10, 5'd5, 5'd0);
      we  = mk(3'd1, 5'd11, 5'd0, 5'd5);
      wa0 = mk(3'd0, 5'd5,  5'd1, 5'd2);
      repeat (2) step();
      rst = 1'b0;

      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full",  32'(bus.full),  32'd0);
      chk("rst_instr", 32'(bus.instruccion), 32'd0);
      chk("rst_issued", 32'(bus.issued), 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_ovf",   32'(bus.ovf),   32'd0);

      // Independent stream
      bus.run = 1'b1;
      exp_issue(wa, 1'b0);
      exp_issue(wb, 1'b1);
      exp_issue(wc, 1'b1);
      push_word(wa);
      push_word(wb);
      push_word(wc);
      drain("drain_indep");

      // Back-to-back RAW
      exp_issue(wa, 1'b0);
`ifdef EMISOR_SCOREBOARD_EN
      exp_bubble();
      exp_bubble();
`endif
      exp_issue(wd, 1'b1);
      push_word(wa);
      push_word(wd);
      drain("drain_raw1");

      // Distance-2 RAW
      exp_issue(wa, 1'b0);
      exp_issue(wb, 1'b1);
`ifdef EMISOR_SCOREBOARD_EN
      exp_bubble();
`endif
      exp_issue(we, 1'b1);
      push_word(wa);
      push_word(wb);
      push_word(we);
      drain("drain_raw2");

      // Same shape with a non-writing producer
      exp_issue(wa0, 1'b0);
      exp_issue(wb, 1'b1);
      exp_issue(we, 1'b1);
      push_word(wa0);
      push_word(wb);
      push_word(we);
      drain("drain_op0");

      // Full / overflow with issue frozen
      bus.run = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_issue(mk(3'd1, 5'(16 + i), 5'(i), 5'(i + 1)), (i != 0));
         push_word(mk(3'd1, 5'(16 + i), 5'(i), 5'(i + 1)));
         if (i == 6) begin
            chk("full_at7", 32'(bus.full),  32'd0);
            chk("count_7",  32'(bus.count), 32'd7);
         end
      end
      chk("full_at8", 32'(bus.full),  32'd1);
      chk("count_8",  32'(bus.count), 32'd8);
      chk("ovf_at8",  32'(bus.ovf),   32'd0);
      push_word(mk(3'd1, 5'd31, 5'd30, 5'd29));
      chk("ovf_at9",   32'(bus.ovf),   32'd1);
      chk("count_9",   32'(bus.count), 32'd8);
      chk("empty_full", 32'(bus.empty), 32'd0);
      bus.run = 1'b1;
      drain("drain_full");
      chk("ovf_sticky", 32'(bus.ovf),   32'd1);
      chk("empty_post", 32'(bus.empty), 32'd1);

      // Reset mid-operation, with a push coinciding with reset
      bus.run = 1'b0;
      push_word(wa);
      push_word(wb);
      push_word(wc);
      chk("count_pre_rst", 32'(bus.count), 32'd3);
      rst          = 1'b1;
      bus.wr_en    = 1'b1;
      bus.wr_instr = wd;
      step();
      rst       = 1'b0;
      bus.wr_en = 1'b0;
      chk("mrst_count",  32'(bus.count), 32'd0);
      chk("mrst_empty",  32'(bus.empty), 32'd1);
      chk("mrst_full",   32'(bus.full),  32'd0);
      chk("mrst_instr",  32'(bus.instruccion), 32'd0);
      chk("mrst_issued", 32'(bus.issued), 32'd0);
      chk("mrst_ovf",    32'(bus.ovf),   32'd0);
      bus.run = 1'b1;
      repeat (6) step();
      chk("mrst_no_issue", 32'(bus.count), 32'd0);
      chk("sb_leftover", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/emisor_instrucciones.md
# emisor_instrucciones

Instruction issue unit driving the 18-bit `instruccion` input of the jericalla pipeline; it is the producer side of that instruction interface. A host pushes instructions into an internal FIFO. The block issues one instruction per cycle on a registered output and inserts bubble (NOP) cycles when a read-after-write hazard against the pipeline's two-stage writeback would occur. Instruction format: op[17:15], WA[14:10], RA1[9:5], RA2[4:0].

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `WE_MASK`, 8'b0001_1110: bit i set means opcode i writes the register bank.
- `NOP_INSTR`, 18'h00000: bubble/idle word. Its opcode must have a clear `WE_MASK` bit.

- `clk_emisor`  in  1: clock; all state updates on the rising edge.
- `rst_emisor`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: push `wr_instr` this edge.
- `wr_instr`  in  18: instruction to enqueue.
- `run`  in  1: issue enable.
- `instruccion`  out  18: registered instruction to the pipeline.
- `issued`  out  1: registered; high while `instruccion` holds a popped FIFO entry.
- `stall`  out  1: registered; high while `instruccion` holds a hazard bubble.
- `full`  out  1: count == DEPTH.
- `empty`  out  1: count == 0.
- `count`  out  $clog2(DEPTH)+1: current occupancy.
- `ovf`  out  1: sticky; a push was dropped.

## Operation
- FIFO uses wrapping read/write pointers of $clog2(DEPTH) bits and a separate occupancy counter.
- Push is accepted if `wr_en` is high and `!full`. A push while full is dropped and sets `ovf`.
- Push and pop in the same cycle leave `count` unchanged. When full, the pop happens first, but the push is still dropped, because acceptance is decided on the pre-edge `full`.
- No bypass: an entry pushed at edge E is eligible to issue no earlier than edge E+1.
- Hazard check: let `head` be the FIFO head and `cur` be the word currently on `instruccion`. `prev` is the word that was on `instruccion` one cycle earlier.
  - `haz` is asserted when, for `cur` or `prev`, `WE_MASK[op]` is set and WA equals head RA1 or head RA2.
- Per-edge decision, in priority order:
  - `!run` or `empty`: `instruccion`←NOP_INSTR, `issued`=0, `stall`=0.
  - `haz`: `instruccion`←NOP_INSTR, `stall`=1, no pop.
  - Otherwise: `instruccion`←`head`, pop, `issued`=1.
- On every edge, `prev` ← `cur`. Bubbles therefore age out producers.
- Reset values:
  - `instruccion`=NOP_INSTR, `prev`=NOP_INSTR.
  - `issued`=0, `stall`=0, `ovf`=0.
  - Pointers and `count` = 0, so `empty`=1 and `full`=0.
- Reset mid-operation discards all queued entries. A push coinciding with reset is ignored.

## Timing
- Issue latency from push to `instruccion`: 1 edge when the FIFO is empty, `run`=1 and there is no hazard.
- Sustained throughput: 1 instruction/cycle for independent instructions.
- Pipeline contract: the word on `instruccion` in cycle k commits its writeback at the end of cycle k+2. Register reads by later words are therefore valid from cycle k+3.
- A consumer issued back-to-back after its producer gets exactly 2 bubbles. A consumer one slot later gets 1 bubble.
- `full`, `empty` and `count` are combinational from registered state, valid the cycle after the edge.
- `run` deasserting freezes the FIFO. Hazard history still ages, because NOPs keep shifting through `cur`/`prev`.

## Configuration
- `EMISOR_SCOREBOARD_EN` defined: hazard interlock as above.
- Not defined: `haz` is tied to 0 and `stall` is constant 0. Instructions issue whenever `run` && `!empty`, and software must pad dependent sequences with NOPs.

## Test plan
- **Reset:** push 3 entries, then assert `rst_emisor` for 1 cycle. Required: `count`=0, `empty`=1, `instruccion`=NOP_INSTR, `issued`=0, `ovf`=0.
- **Independent stream:** push A (op1, WA5, RA 1,2), B (op1, WA6, RA 3,4) and C (op1, WA7, RA 8,9) with `run`=1. Required: A, B, C appear on consecutive cycles, `issued`=1 each, `stall` never set.
- **Back-to-back RAW** (macro defined): A (op1, WA5), then D (op1, WA10, RA1=5). Required: A, NOP, NOP, D, with `stall`=1 on both NOP cycles.
- **Distance-2 RAW:** A (WA5), B (WA6, RA 3,4), E (RA2=5). Required: A, B, NOP, E. Repeat with op0 as producer: no stall.
- **Full/overflow** (DEPTH=8, `run`=0): push 9 words. Required: `full`=1 after the 8th, `count`=8, `ovf`=1 after the 9th. Then set `run`=1 and the 8 accepted words drain in order with no data loss.
- **Macro undefined:** the same sequence as the back-to-back RAW case. Required: A, D issue on consecutive cycles, `stall`=0.
